// File: rtl/anubis_seq_ctrl.sv
// Request sequencer for the Anubis_2 core: key load, data load, rounds, result capture.
// Optional key cache enabled with `define ANUBIS_SEQ_KEY_CACHE_EN.
module anubis_seq_ctrl #(
  parameter int unsigned KEY_CYCLES   = 3,
  parameter int unsigned ROUND_CYCLES = 13,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [127:0]     req_key_i,
  input  logic [127:0]     req_data_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [127:0]     res_data_o,
  output logic             core_rst_o,
  output logic [1:0]       core_order_o,
  output logic [127:0]     core_data_o,
  input  logic [127:0]     core_data_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] key_loads_o
);

  localparam int unsigned BLK_W   = 128;
  localparam int unsigned MAX_CYC = (KEY_CYCLES > ROUND_CYCLES) ? KEY_CYCLES : ROUND_CYCLES;
  localparam int unsigned PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [PH_W-1:0] KEY_LAST = PH_W'(KEY_CYCLES - 1);
  localparam logic [PH_W-1:0] RUN_LAST = PH_W'(ROUND_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_KEY, S_LOAD, S_RUN, S_HOLD} state_e;

  state_e            state_q, state_nx;
  logic [PH_W-1:0]   phase_q, phase_nx;
  logic [BLK_W-1:0]  key_q, data_q;
  logic [BLK_W-1:0]  key_src, data_src;
  logic              req_fire, cache_hit;

  logic              req_ready_nx, res_valid_nx, core_rst_nx, busy_nx;
  logic [1:0]        core_order_nx;
  logic [BLK_W-1:0]  res_data_nx, core_data_nx;
  logic [CNT_W-1:0]  key_loads_nx;

  assign req_fire = req_valid_i && (state_q == S_IDLE);

`ifdef ANUBIS_SEQ_KEY_CACHE_EN
  logic [BLK_W-1:0] cache_key_q;
  logic             cache_vld_q;

  assign cache_hit = cache_vld_q && (req_key_i == cache_key_q);

  // Remember the key the core currently holds once its load phase completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_key_q <= '0;
      cache_vld_q <= 1'b0;
    end else if (state_q == S_KEY && state_nx == S_LOAD) begin
      cache_key_q <= key_q;
      cache_vld_q <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // Request capture; the core sees the live request on the entry cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q  <= '0;
      data_q <= '0;
    end else if (req_fire) begin
      key_q  <= req_key_i;
      data_q <= req_data_i;
    end
  end

  assign key_src  = (state_q == S_IDLE) ? req_key_i  : key_q;
  assign data_src = (state_q == S_IDLE) ? req_data_i : data_q;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      req_ready_o  <= 1'b1;
      res_valid_o  <= 1'b0;
      res_data_o   <= '0;
      core_rst_o   <= 1'b0;
      core_order_o <= 2'b11;
      core_data_o  <= '0;
      busy_o       <= 1'b0;
      key_loads_o  <= '0;
    end else begin
      state_q      <= state_nx;
      phase_q      <= phase_nx;
      req_ready_o  <= req_ready_nx;
      res_valid_o  <= res_valid_nx;
      res_data_o   <= res_data_nx;
      core_rst_o   <= core_rst_nx;
      core_order_o <= core_order_nx;
      core_data_o  <= core_data_nx;
      busy_o       <= busy_nx;
      key_loads_o  <= key_loads_nx;
    end
  end

  // Next state and phase counter (cleared on every state entry).
  always_comb begin
    state_nx = state_q;
    phase_nx = '0;
    case (state_q)
      S_IDLE: if (req_fire) state_nx = cache_hit ? S_LOAD : S_KEY;
      S_KEY:  if (phase_q == KEY_LAST) state_nx = S_LOAD;
      S_LOAD: state_nx = S_RUN;
      S_RUN:  if (phase_q == RUN_LAST) state_nx = S_HOLD;
      S_HOLD: if (res_ready_i) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (state_nx == state_q && (state_q == S_KEY || state_q == S_RUN))
      phase_nx = phase_q + PH_W'(1);
  end

  // Outputs for the coming cycle, derived from the state being entered.
  always_comb begin
    req_ready_nx  = (state_nx == S_IDLE);
    busy_nx       = (state_nx != S_IDLE);
    res_valid_nx  = (state_nx == S_HOLD);
    core_rst_nx   = (state_nx == S_KEY) && (state_q != S_KEY);
    key_loads_nx  = key_loads_o + CNT_W'(core_rst_nx);
    res_data_nx   = res_data_o;
    core_data_nx  = core_data_o;
    core_order_nx = 2'b11;
    if (state_q == S_RUN && state_nx == S_HOLD)
      res_data_nx = core_data_i;
    case (state_nx)
      S_KEY: begin
        core_order_nx = 2'b00;
        core_data_nx  = key_src;
      end
      S_LOAD: begin
        core_order_nx = 2'b01;
        core_data_nx  = data_src;
      end
      S_RUN: begin
        core_order_nx = 2'b10;
        core_data_nx  = data_src;
      end
      default: core_order_nx = 2'b11;
    endcase
  end

endmodule
